detector_flanco_multicanal: RTL
===============================

Name: detector_flanco_multicanal

Overview:
- Parametrised, multi-channel successor to the single-button negative-edge detector.
- Per channel: 2-FF synchroniser, counter-based debounce filter, configurable edge detection (rising / falling / both).
- Each detected edge produces one single-cycle pulse.
- Sits between the board push-buttons/switches and the control FSMs that consume button events.

Parameters:
- CANALES, 4, number of independent input channels (>=1).
- ESTABLE, 16, cycles the synchronised input must differ from the filtered level before that level updates (>=1).
- MODO, 1, edge select: 0 = rising, 1 = falling, 2 = both; any other value behaves as 1.
- REPETIR_RETARDO, 50000, hold cycles before the first auto-repeat pulse (Optional Feature only; >=1).
- REPETIR_PERIODO, 10000, cycles between subsequent auto-repeat pulses (Optional Feature only; >=1).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- boton  input  CANALES  raw asynchronous button inputs, bit i = channel i.
- salida  output  CANALES  one-cycle event pulse per channel.
- nivel  output  CANALES  debounced, filtered level per channel.

Behaviour:
- Reset (sampled on clk while reset=1):
  - synchroniser flops, nivel, salida and all counters go to 0.
  - Reset overrides all other activity, including mid-count and mid-repeat.
  - First edge after reset release behaves as the first edge after power-up with all levels 0.
- Synchroniser: s1 <= boton[i]; s2 <= s1. Only s2 feeds the filter.
- Debounce counter cnt[i], width $clog2(ESTABLE+1), evaluated every clk:
  - s2 == nivel: cnt <= 0; nivel holds.
  - s2 != nivel and cnt < ESTABLE-1: cnt <= cnt+1.
  - s2 != nivel and cnt == ESTABLE-1: nivel <= s2; cnt <= 0.
  - A glitch shorter than ESTABLE cycles (s2 returns to nivel) clears cnt and produces no change and no pulse.
- Edge pulse:
  - salida[i] is registered and goes high on the same clk edge on which nivel[i] changes, if the change matches MODO:
    - MODO 0: 0->1 only.
    - MODO 1: 1->0 only.
    - MODO 2: either direction.
  - Width is exactly 1 cycle. Non-matching changes update nivel silently.
- Latency:
  - Input stable from before clk edge 1 -> nivel/salida update on edge ESTABLE+2.
  - With ESTABLE=1: 3 edges.
- Channels are fully independent; simultaneous events on several channels produce simultaneous pulses.
- Consecutive pulses on one channel are at least ESTABLE cycles apart.

Optional Feature:
- Macro: DETECTOR_FLANCO_REPETIR_EN.
- Defined: per-channel auto-repeat, active while nivel[i] is at the "pressed" level (1 for MODO 0 and 2, 0 for MODO 1).
  - Timer rep[i] clears on the cycle of the press pulse.
  - Extra salida pulse when the timer reaches REPETIR_RETARDO cycles after the press pulse, then every REPETIR_PERIODO cycles.
  - Release (nivel leaves pressed level) clears the timer immediately; no repeat pulse is emitted on or after the release edge.
  - Repeat pulses never coincide with, or extend, a debounce pulse.
- Not defined: no repeat timer logic present; one pulse per qualifying edge; REPETIR_* parameters ignored.

Test Plan:
1. CANALES=2, ESTABLE=4, MODO=1: reset 3 cycles, boton=2'b11 held 10 cycles, then boton[0]=0 -> nivel=2'b11 by edge 6; salida[0]=1 for one cycle exactly 6 edges after the fall; salida[1] stays 0.
2. ESTABLE=4, MODO=0: 3-cycle high glitch on boton[1] -> nivel and salida unchanged, cnt returns to 0; a 4-cycle-stable high -> single pulse on salida[1].
3. MODO=2, ESTABLE=4: press then release boton[0], each held 8 cycles -> exactly two 1-cycle pulses, 8 cycles apart.
4. Both channels fall on the same cycle (MODO=1) -> salida=2'b11 for one cycle; assert reset while a channel has cnt=2 -> nivel, salida and cnt all 0 next cycle; no pulse follows.
5. With DETECTOR_FLANCO_REPETIR_EN, MODO=0, ESTABLE=2, REPETIR_RETARDO=20, REPETIR_PERIODO=5: hold boton[0] high 40 cycles -> pulses at press, +20, +25, +30, +35; release -> no further pulses.
6. Without the macro, same stimulus as scenario 5 -> single pulse at press only.

Source files
------------

// File: rtl/detector_flanco_multicanal.sv
// -----------------------------------------------------------------------------
// detector_flanco_multicanal
//   Multi-channel button edge detector. Each channel synchronises its raw input
//   through two flops, debounces it with a stability counter, and emits a
//   one-cycle pulse when the filtered level changes in the selected direction.
//
//   Optional build macro: DETECTOR_FLANCO_REPETIR_EN
//     When defined, each channel also auto-repeats while held at the pressed
//     level: a first extra pulse REPETIR_RETARDO cycles after the press pulse,
//     then one every REPETIR_PERIODO cycles until release.
//
//   Parameters
//     CANALES          number of independent channels (>=1)
//     ESTABLE          cycles of disagreement needed to update nivel (>=1)
//     MODO             0 = rising, 1 = falling, 2 = both; others act as 1
//     REPETIR_RETARDO  hold cycles before the first repeat pulse (>=1)
//     REPETIR_PERIODO  cycles between later repeat pulses (>=1)
//
//   Ports
//     clk     in   system clock, rising edge
//     reset   in   synchronous, active-high
//     boton   in   [CANALES] raw asynchronous button inputs
//     salida  out  [CANALES] one-cycle event pulse per channel
//     nivel   out  [CANALES] debounced level per channel
// -----------------------------------------------------------------------------

// One channel: synchroniser, debounce filter, edge pulse (and optional repeat).
module detectorCanal #(
    parameter int ESTABLE = 16,
    parameter int MODO    = 1
`ifdef DETECTOR_FLANCO_REPETIR_EN
    ,
    parameter int REPETIR_RETARDO = 50000,
    parameter int REPETIR_PERIODO = 10000
`endif
) (
    input  logic clk,
    input  logic reset,
    input  logic boton,
    output logic salida,
    output logic nivel
);
    localparam int CW = $clog2(ESTABLE + 1);
    // Unsupported mode codes fall back to falling-edge detection.
    localparam int MODO_EF = (MODO == 0 || MODO == 2) ? MODO : 1;
    // Level that counts as "held down" for auto-repeat purposes.
    localparam logic PRESIONADO = (MODO_EF == 1) ? 1'b0 : 1'b1;

    logic          s1, s2;
    logic [CW-1:0] cnt;
    logic          cambia;
    logic          flanco;

    // nivel takes the synchronised value on this edge.
    assign cambia = (s2 != nivel) && (cnt == CW'(ESTABLE - 1));

    always_comb begin
        flanco = 1'b0;
        if (cambia) begin
            case (MODO_EF)
                0:       flanco = s2;
                1:       flanco = ~s2;
                default: flanco = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            nivel <= 1'b0;
        end else begin
            s1 <= boton;
            s2 <= s1;
            if (s2 == nivel) begin
                cnt <= '0;
            end else if (cambia) begin
                nivel <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef DETECTOR_FLANCO_REPETIR_EN
    localparam int RMAX = (REPETIR_RETARDO > REPETIR_PERIODO) ? REPETIR_RETARDO
                                                              : REPETIR_PERIODO;
    localparam int RW   = $clog2(RMAX + 1);

    logic [RW-1:0] rep, repSig, repLimite;
    logic          armado;   // a press pulse was issued and the key is still held
    logic          primero;  // still waiting for the initial (longer) delay
    logic          repPulso;

    assign repSig    = rep + 1'b1;
    assign repLimite = primero ? RW'(REPETIR_RETARDO) : RW'(REPETIR_PERIODO);

    // Never fires on a nivel-change edge, so it cannot overlap a debounce
    // pulse nor follow a release.
    always_comb begin
        repPulso = 1'b0;
        if (armado && !cambia && nivel == PRESIONADO && repSig == repLimite)
            repPulso = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rep     <= '0;
            armado  <= 1'b0;
            primero <= 1'b0;
            salida  <= 1'b0;
        end else begin
            salida <= flanco | repPulso;
            if (cambia) begin
                // Arm only on a real press pulse; any release disarms.
                rep     <= '0;
                armado  <= flanco && (s2 == PRESIONADO);
                primero <= 1'b1;
            end else if (armado) begin
                if (repPulso) begin
                    rep     <= '0;
                    primero <= 1'b0;
                end else begin
                    rep <= repSig;
                end
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) salida <= 1'b0;
        else       salida <= flanco;
    end
`endif
endmodule

module detector_flanco_multicanal #(
    parameter int CANALES         = 4,
    parameter int ESTABLE         = 16,
    parameter int MODO            = 1,
    parameter int REPETIR_RETARDO = 50000,
    parameter int REPETIR_PERIODO = 10000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CANALES-1:0] boton,
    output logic [CANALES-1:0] salida,
    output logic [CANALES-1:0] nivel
);
    if (CANALES < 1 || ESTABLE < 1 || REPETIR_RETARDO < 1 || REPETIR_PERIODO < 1)
    begin : gParamErr
        $error("detector_flanco_multicanal: parameter out of range");
    end

    for (genvar i = 0; i < CANALES; i++) begin : gCanal
        detectorCanal #(
            .ESTABLE(ESTABLE),
            .MODO   (MODO)
`ifdef DETECTOR_FLANCO_REPETIR_EN
            ,
            .REPETIR_RETARDO(REPETIR_RETARDO),
            .REPETIR_PERIODO(REPETIR_PERIODO)
`endif
        ) uCanal (
            .clk   (clk),
            .reset (reset),
            .boton (boton[i]),
            .salida(salida[i]),
            .nivel (nivel[i])
        );
    end
endmodule
